// File: rtl/pht_update_ctrl_pkg.sv
// Shared constants for the PHT update controller: 2-bit counter encodings, FSM states
// and the saturating-counter update function.
package pht_update_ctrl_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    READ,
    WRITE
  } state_t;

  // Taken moves the counter toward ST, not-taken moves it toward SNT; both ends stick.
  function automatic logic [1:0] sat(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST) ? ST : ctr + 2'd1;
    else       return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy counter; DEPTH must be a power of two (>= 2).
// The caller guarantees no push while full and no pop while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/pht_update_ctrl.sv
// PHT write-side controller: sweeps the table to INIT_VAL after reset, then serialises
// queued counter updates as read-modify-write pairs on the RAM's write-side port.
module pht_update_ctrl
  import pht_update_ctrl_pkg::*;
#(
  parameter int         ADDRLEN    = 10,
  parameter int         DEPTH      = 1024,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] INIT_VAL   = 2'b01
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               upd_valid,
  input  logic [ADDRLEN-1:0] upd_addr,
  input  logic               upd_taken,
  output logic               upd_ready,
  output logic [ADDRLEN-1:0] ram_addr,
  input  logic [1:0]         ram_rdata,
  output logic [1:0]         ram_wdata,
  output logic               ram_we,
  output logic               init_done,
  output logic               busy
);

  localparam logic [ADDRLEN-1:0] LAST = ADDRLEN'(DEPTH - 1);

  state_t             state;
  logic [ADDRLEN-1:0] sweep;
  logic [ADDRLEN-1:0] op_addr;
  logic               op_taken;

  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic               fifo_full;
  logic [ADDRLEN:0]   fifo_dout;

  // Ready depends only on registers, so a requester can never form a loop through it.
  assign upd_ready = init_done && !fifo_full;
  assign push      = upd_valid && upd_ready;
  assign pop       = !fifo_empty && ((state == IDLE) || (state == WRITE));
  assign busy      = (state != IDLE) || !fifo_empty;

  sync_fifo #(
    .WIDTH (ADDRLEN + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({upd_addr, upd_taken}),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      sweep     <= '0;
      op_addr   <= '0;
      op_taken  <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (sweep == LAST) begin
            state     <= IDLE;
            init_done <= 1'b1;
          end else begin
            sweep <= sweep + 1'b1;
          end
        end
        IDLE, WRITE: begin
          if (pop) begin
            {op_addr, op_taken} <= fifo_dout;
            state               <= READ;
          end else begin
            state <= IDLE;
          end
        end
        READ:    state <= WRITE;
        default: state <= INIT;
      endcase
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      INIT: begin
        ram_we    = 1'b1;
        ram_addr  = sweep;
        ram_wdata = INIT_VAL;
      end
      READ: begin
        ram_addr = op_addr;
      end
      WRITE: begin
        ram_we    = 1'b1;
        ram_addr  = op_addr;
        ram_wdata = sat(ram_rdata, op_taken);
      end
      default: ;
    endcase
  end

endmodule
